// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: inst bit map, idle word,
// FSM state encoding, latched job record and address helpers.
package core_ctrl_pkg;

  localparam int psum_bw = 16;
  localparam int inst_w  = 35;

  localparam int b_mode        = 34;
  localparam int b_acc         = 33;
  localparam int b_psum_cen    = 32;
  localparam int b_psum_wen    = 31;
  localparam int b_psum_addr   = 20;
  localparam int b_xmem_cen    = 19;
  localparam int b_xmem_wen    = 18;
  localparam int b_xmem_addr   = 7;
  localparam int b_ofifo_rd    = 6;
  localparam int b_l0_rd       = 3;
  localparam int b_l0_wr       = 2;
  localparam int b_execute     = 1;
  localparam int b_kernel_load = 0;

  // Both memories deselected, no datapath strobes.
  localparam logic [inst_w-1:0] IDLE_INST = (35'd1 << b_psum_cen) | (35'd1 << b_psum_wen)
                                          | (35'd1 << b_xmem_cen) | (35'd1 << b_xmem_wen);

  typedef enum logic [2:0] {IDLE, W_RD, KWAIT, A_RD, DRAIN, ACC, DONE} state_t;

  typedef struct packed {
    logic        mode;
    logic [10:0] w_base;
    logic [10:0] a_base;
    logic [10:0] len;
    logic [3:0]  npass;
  } job_t;

  function automatic logic [10:0] w_addr(input logic [10:0] base, input logic [3:0] pass,
                                         input int unsigned rows, input logic [11:0] idx);
    logic [31:0] sum;
    sum = 32'(base) + 32'(pass) * rows + 32'(idx);
    return sum[10:0];
  endfunction

  // Matches the core's sequential psum write order: pass-major, output-minor.
  function automatic logic [10:0] psum_addr(input logic [3:0] q, input logic [10:0] o,
                                            input logic [10:0] n);
    logic [14:0] prod;
    prod = 15'(q) * 15'(n);
    return prod[10:0] + o;
  endfunction

endpackage

// File: rtl/core_inst_seq_if.sv
// Host/core-facing bundle of the instruction sequencer: job request, OFIFO status,
// and the generated instruction word with job status.
interface core_inst_seq_if;
  import core_ctrl_pkg::*;

  logic              start;
  logic              mode_2b;
  logic [10:0]       w_base;
  logic [10:0]       a_base;
  logic [10:0]       len;
  logic [3:0]        npass;
  logic              ofifo_valid;
  logic [inst_w-1:0] inst;
  logic              busy;
  logic              done;

  modport master (output start, mode_2b, w_base, a_base, len, npass, ofifo_valid,
                  input  inst, busy, done);

  modport slave  (input  start, mode_2b, w_base, a_base, len, npass, ofifo_valid,
                  output inst, busy, done);
endinterface

// File: rtl/core_l0_feed_pipe.sv
// Two-stage delay line that turns an xmem read strobe into the L0 write (one cycle
// later) and the L0 read with kernel_load/execute (two cycles later).
module core_l0_feed_pipe (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic kind,
  output logic l0_wr,
  output logic l0_rd,
  output logic kernel_load,
  output logic execute
);

  logic [1:0] vld_reg;
  logic [1:0] kind_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg  <= 2'b00;
      kind_reg <= 2'b00;
    end else begin
      vld_reg  <= {vld_reg[0], issue};
      kind_reg <= {kind_reg[0], kind};
    end
  end

  // kind=1 marks a weight (kernel) read, kind=0 an activation read.
  assign l0_wr       = vld_reg[0];
  assign l0_rd       = vld_reg[1];
  assign kernel_load = vld_reg[1] & kind_reg[1];
  assign execute     = vld_reg[1] & ~kind_reg[1];

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer: per pass loads a weight tile, streams activations, drains the
// OFIFO, then reads back all psums with acc=1. All outputs come straight from flops.
module core_inst_seq
  import core_ctrl_pkg::*;
#(
  parameter int row  = 8,
  parameter int col  = 8,
  parameter int KGAP = col
) (
  input  logic           clk,
  input  logic           reset,
  core_inst_seq_if.slave bus
);

  state_t            state_reg, state_next;
  job_t              job_reg, job_next;
  logic [11:0]       cnt_reg, cnt_next;
  logic [3:0]        p_reg, p_next;
  logic [3:0]        q_reg, q_next;
  logic [10:0]       o_reg, o_next;
  logic              gap_reg, gap_next;
  logic              pop;

  logic [inst_w-1:0] inst_base_reg, inst_base_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              issue_reg, issue_next;
  logic              kind_reg, kind_next;

  logic              l0_wr, l0_rd, kernel_load, execute;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      job_reg       <= '0;
      cnt_reg       <= '0;
      p_reg         <= '0;
      q_reg         <= '0;
      o_reg         <= '0;
      gap_reg       <= 1'b0;
      inst_base_reg <= IDLE_INST;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      issue_reg     <= 1'b0;
      kind_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      job_reg       <= job_next;
      cnt_reg       <= cnt_next;
      p_reg         <= p_next;
      q_reg         <= q_next;
      o_reg         <= o_next;
      gap_reg       <= gap_next;
      inst_base_reg <= inst_base_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      issue_reg     <= issue_next;
      kind_reg      <= kind_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    job_next   = job_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;
    q_next     = q_reg;
    o_next     = o_reg;
    gap_next   = gap_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          job_next.mode   = bus.mode_2b;
          job_next.w_base = bus.w_base;
          job_next.a_base = bus.a_base;
          job_next.len    = bus.len;
          job_next.npass  = bus.npass;
          cnt_next        = '0;
          p_next          = '0;
          q_next          = '0;
          o_next          = '0;
          gap_next        = 1'b0;
          state_next      = (bus.npass != 4'd0 && bus.len != 11'd0) ? W_RD : DONE;
        end
      end
      // Two extra cycles let the last read reach l0_rd before moving on.
      W_RD: begin
        if (cnt_reg == 12'(row + 1)) begin
          state_next = KWAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      KWAIT: begin
        if (cnt_reg + 12'd1 >= 12'(KGAP)) begin
          state_next = A_RD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      A_RD: begin
        if (cnt_reg == {1'b0, job_reg.len} + 12'd1) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      DRAIN: begin
        if (cnt_reg == {1'b0, job_reg.len}) begin
          cnt_next = '0;
          if (({1'b0, p_reg} + 5'd1) < {1'b0, job_reg.npass}) begin
            state_next = W_RD;
            p_next     = p_reg + 4'd1;
          end else begin
            state_next = ACC;
            q_next     = '0;
            o_next     = '0;
            gap_next   = 1'b0;
          end
        end else if (bus.ofifo_valid) begin
          pop      = 1'b1;
          cnt_next = cnt_reg + 12'd1;
        end
      end
      ACC: begin
        if (gap_reg) begin
          gap_next = 1'b0;
          q_next   = '0;
          if (o_reg == job_reg.len - 11'd1) state_next = DONE;
          else                              o_next     = o_reg + 11'd1;
        end else if (q_reg == job_reg.npass - 4'd1) begin
          gap_next = 1'b1;
        end else begin
          q_next = q_reg + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the next-cycle view so the registered word lines up with the state register.
  always_comb begin
    inst_base_next = IDLE_INST;
    issue_next     = 1'b0;
    kind_next      = 1'b0;
    busy_next      = (state_next != IDLE) && (state_next != DONE);
    done_next      = (state_next == DONE);
    if (busy_next) inst_base_next[b_mode] = job_next.mode;
    case (state_next)
      W_RD: begin
        if (cnt_next < 12'(row)) begin
          inst_base_next[b_xmem_cen]       = 1'b0;
          inst_base_next[b_xmem_addr +: 11] = w_addr(job_next.w_base, p_next, row, cnt_next);
          issue_next = 1'b1;
          kind_next  = 1'b1;
        end
      end
      A_RD: begin
        if (cnt_next < {1'b0, job_next.len}) begin
          inst_base_next[b_xmem_cen]       = 1'b0;
          inst_base_next[b_xmem_addr +: 11] = job_next.a_base + cnt_next[10:0];
          issue_next = 1'b1;
        end
      end
      DRAIN: begin
        inst_base_next[b_psum_wen] = 1'b0;
        inst_base_next[b_ofifo_rd] = pop;
      end
      ACC: begin
        if (!gap_next) begin
          inst_base_next[b_acc]             = 1'b1;
          inst_base_next[b_psum_cen]        = 1'b0;
          inst_base_next[b_psum_addr +: 11] = psum_addr(q_next, o_next, job_next.len);
        end
      end
      default: ;
    endcase
  end

  core_l0_feed_pipe u_feed (
    .clk         (clk),
    .reset       (reset),
    .issue       (issue_reg),
    .kind        (kind_reg),
    .l0_wr       (l0_wr),
    .l0_rd       (l0_rd),
    .kernel_load (kernel_load),
    .execute     (execute)
  );

  assign bus.inst = inst_base_reg | {31'd0, l0_rd, l0_wr, execute, kernel_load};
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: a negedge monitor logs every xmem/psum access and
// strobe, and one linear initial block drives jobs and checks the log.
module tb_core_inst_seq;

  localparam logic [34:0] IDLE_EXP = 35'h1_800C_0000;
  localparam int          GAP      = 4095;

  logic clk = 1'b0;
  logic rst = 1'b1;

  core_inst_seq_if bus();

  core_inst_seq dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  int xq[$];
  int psq[$];
  int n_kl = 0, n_ex = 0, n_pop = 0, n_done = 0;
  int pipe_err = 0, acc_err = 0, ovl_err = 0, mode_err = 0, cen_low = 0;
  bit exp_mode = 1'b0;
  logic prev_xrd = 1'b0, prev_l0wr = 1'b0, prev_prd = 1'b0;
  logic xrd, prd;

  always @(negedge clk) begin
    if (rst) begin
      prev_xrd  = 1'b0;
      prev_l0wr = 1'b0;
      prev_prd  = 1'b0;
    end else begin
      xrd = !bus.inst[19] && bus.inst[18];
      prd = !bus.inst[32] && bus.inst[31];
      if (xrd) xq.push_back(int'(bus.inst[17:7]));
      if (bus.inst[2] !== prev_xrd || bus.inst[3] !== prev_l0wr) pipe_err++;
      if (bus.inst[0]) n_kl++;
      if (bus.inst[1]) n_ex++;
      if (bus.inst[6]) n_pop++;
      if (prd) psq.push_back(int'(bus.inst[30:20]));
      else if (prev_prd) psq.push_back(GAP);
      if (bus.inst[33] !== prd) acc_err++;
      if (prd && bus.inst[6]) ovl_err++;
      if (bus.busy && bus.inst[34] !== exp_mode) mode_err++;
      if (bus.inst[19] === 1'b0 || bus.inst[32] === 1'b0) cen_low++;
      if (bus.done) n_done++;
      prev_xrd  = xrd;
      prev_l0wr = bus.inst[2];
      prev_prd  = prd;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input bit mode, input int wb, input int ab, input int ln, input int np);
    tick();
    exp_mode    = mode;
    bus.mode_2b = mode;
    bus.w_base  = 11'(wb);
    bus.a_base  = 11'(ab);
    bus.len     = 11'(ln);
    bus.npass   = 4'(np);
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (bus.done) seen = 1'b1;
      else tick();
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  int xs, ps, pop0, kl0, ex0, pe0, ae0, oe0, me0, nd0, cl0;
  int exp_x[$];
  int exp_p[$];
  bit reached;
  int stall_rd, stall_busy;

  task automatic snap();
    xs = xq.size(); ps = psq.size(); pop0 = n_pop; kl0 = n_kl; ex0 = n_ex;
    pe0 = pipe_err; ae0 = acc_err; oe0 = ovl_err; me0 = mode_err; nd0 = n_done; cl0 = cen_low;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_xcount"}, 64'(xq.size() - xs), 64'(exp_x.size()));
    for (int i = 0; i < exp_x.size() && xs + i < xq.size(); i++)
      chk($sformatf("%s_xaddr%0d", tag, i), 64'(xq[xs + i]), 64'(exp_x[i]));
    chk({tag, "_pcount"}, 64'(psq.size() - ps), 64'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && ps + i < psq.size(); i++)
      chk($sformatf("%s_psum%0d", tag, i), 64'(psq[ps + i]), 64'(exp_p[i]));
    chk({tag, "_pipe"}, 64'(pipe_err - pe0), 64'd0);
    chk({tag, "_acc"},  64'(acc_err - ae0), 64'd0);
    chk({tag, "_ovl"},  64'(ovl_err - oe0), 64'd0);
    chk({tag, "_mode"}, 64'(mode_err - me0), 64'd0);
    chk({tag, "_done1"}, 64'(n_done - nd0), 64'd1);
    $display("job %s: xreads=%0d psum_events=%0d pops=%0d kload=%0d exec=%0d",
             tag, xq.size() - xs, psq.size() - ps, n_pop - pop0, n_kl - kl0, n_ex - ex0);
  endtask

  initial begin
    bus.start = 1'b0; bus.mode_2b = 1'b0; bus.w_base = '0; bus.a_base = '0;
    bus.len = '0; bus.npass = '0; bus.ofifo_valid = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_inst", 64'(bus.inst), 64'(IDLE_EXP));
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    tick();

    // 1: reset asserted during activation reads
    snap();
    start_job(1'b0, 0, 16, 4, 1);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      tick();
      if (xq.size() > xs + 8) reached = 1'b1;
    end
    chk("t1_reach_ard", 64'(reached), 64'd1);
    if (reached) chk("t1_first_act", 64'(xq[xs + 8]), 64'd16);
    #1 rst = 1'b1;
    #1;
    chk("t1_inst_idle", 64'(bus.inst), 64'(IDLE_EXP));
    chk("t1_busy", 64'(bus.busy), 64'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t1_no_done", 64'(n_done - nd0), 64'd0);
    chk("t1_idle_after", 64'(bus.inst), 64'(IDLE_EXP));
    $display("job t1: aborted by reset, done pulses=%0d", n_done - nd0);

    // 2: single pass, len=4
    snap();
    exp_x.delete(); exp_p.delete();
    for (int i = 0; i < 8; i++) exp_x.push_back(i);
    for (int j = 0; j < 4; j++) exp_x.push_back(16 + j);
    for (int o = 0; o < 4; o++) begin exp_p.push_back(o); exp_p.push_back(GAP); end
    start_job(1'b0, 0, 16, 4, 1);
    chk("t2_busy", 64'(bus.busy), 64'd1);
    wait_done("t2_done", 300);
    chk("t2_done_busy", 64'(bus.busy), 64'd0);
    chk("t2_pops", 64'(n_pop - pop0), 64'd4);
    chk("t2_kload", 64'(n_kl - kl0), 64'd8);
    chk("t2_exec", 64'(n_ex - ex0), 64'd4);
    check_log("t2");
    tick();
    chk("t2_done_pulse", 64'(bus.done), 64'd0);
    chk("t2_idle_inst", 64'(bus.inst), 64'(IDLE_EXP));

    // 3: three passes, len=2
    snap();
    exp_x.delete(); exp_p.delete();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) exp_x.push_back(p * 8 + i);
      exp_x.push_back(100); exp_x.push_back(101);
    end
    for (int o = 0; o < 2; o++) begin
      for (int q = 0; q < 3; q++) exp_p.push_back(q * 2 + o);
      exp_p.push_back(GAP);
    end
    start_job(1'b0, 0, 100, 2, 3);
    wait_done("t3_done", 500);
    chk("t3_pops", 64'(n_pop - pop0), 64'd6);
    chk("t3_kload", 64'(n_kl - kl0), 64'd24);
    check_log("t3");

    // 4: OFIFO empty for 10 cycles while draining
    snap();
    exp_x.delete(); exp_p.delete();
    for (int i = 0; i < 8; i++) exp_x.push_back(i);
    exp_x.push_back(50); exp_x.push_back(51);
    exp_p.push_back(0); exp_p.push_back(GAP); exp_p.push_back(1); exp_p.push_back(GAP);
    bus.ofifo_valid = 1'b0;
    start_job(1'b0, 0, 50, 2, 1);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      tick();
      if (n_ex - ex0 >= 2) reached = 1'b1;
    end
    chk("t4_reach_drain", 64'(reached), 64'd1);
    stall_rd = 0; stall_busy = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.inst[6] !== 1'b0) stall_rd++;
      if (bus.busy === 1'b1) stall_busy++;
    end
    chk("t4_no_rd", 64'(stall_rd), 64'd0);
    chk("t4_held_busy", 64'(stall_busy), 64'd10);
    chk("t4_no_psum", 64'(psq.size() - ps), 64'd0);
    bus.ofifo_valid = 1'b1;
    wait_done("t4_done", 100);
    chk("t4_pops", 64'(n_pop - pop0), 64'd2);
    check_log("t4");

    // 5: zero-length and zero-pass jobs finish without memory access
    snap();
    start_job(1'b0, 0, 0, 0, 3);
    chk("t5_len0_done", 64'(bus.done), 64'd1);
    chk("t5_len0_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("t5_len0_pulse", 64'(bus.done), 64'd0);
    start_job(1'b0, 0, 0, 5, 0);
    chk("t5_np0_done", 64'(bus.done), 64'd1);
    tick();
    chk("t5_cen_high", 64'(cen_low - cl0), 64'd0);
    chk("t5_no_xread", 64'(xq.size() - xs), 64'd0);
    chk("t5_two_done", 64'(n_done - nd0), 64'd2);
    $display("job t5: zero-count jobs, done pulses=%0d", n_done - nd0);

    // 6: mode latched, address wrap, start while busy ignored
    snap();
    exp_x.delete(); exp_p.delete();
    for (int i = 0; i < 8; i++) exp_x.push_back((2044 + i) % 2048);
    for (int j = 0; j < 3; j++) exp_x.push_back(j);
    for (int o = 0; o < 3; o++) begin exp_p.push_back(o); exp_p.push_back(GAP); end
    start_job(1'b1, 2044, 0, 3, 1);
    repeat (6) tick();
    bus.mode_2b = 1'b0; bus.len = 11'd7; bus.npass = 4'd2; bus.w_base = 11'd500;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6_busy_kept", 64'(bus.busy), 64'd1);
    wait_done("t6_done", 300);
    check_log("t6");
    repeat (3) tick();
    chk("t6_ignored", 64'(n_done - nd0), 64'd1);
    chk("t6_idle_busy", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
